// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//
// Purpose: groups the request/response handshake of the load/store unit and
// its port towards the downstream data memory into one bundle.
//
// Signals:
//   req_valid      requester -> LSU  access request present
//   req_ready      LSU -> requester  unit idle, request accepted on valid & ready
//   req_store      requester -> LSU  1 = store, 0 = load
//   req_size       requester -> LSU  00 byte, 01 half, 10 word, 11 doubleword
//   req_unsigned   requester -> LSU  load zero-extends when 1, sign-extends when 0
//   req_addr       requester -> LSU  byte address, little-endian
//   req_wdata      requester -> LSU  store data, valid bits in the LSBs
//   resp_valid     LSU -> requester  one-cycle completion pulse
//   resp_rdata     LSU -> requester  extended load data, 0 for stores
//   resp_err       LSU -> requester  misaligned access, qualified by resp_valid
//   mem_l          LSU -> memory     write enable
//   mem_address    LSU -> memory     doubleword index (byte address >> 3)
//   mem_write_data LSU -> memory     doubleword to write
//   mem_q          memory -> LSU     combinational read of mem_address
//
// Modports: slave = the load/store unit, master = requester plus memory model.
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_l;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_q;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_l, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_l, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose: executes one byte/half/word/doubleword load or store at a time
// against a doubleword-wide data memory with a combinational read port.
// Sub-doubleword stores are done as read-modify-write. Loads are extracted
// from the addressed bytes and zero- or sign-extended to 64 bits.
//
// Ports:
//   clk  input   single clock, all state changes on the rising edge
//   rst  input   asynchronous, active-high reset
//   bus  load_store_unit_if.slave  request/response handshake + memory port
//
// Configuration macro:
//   LSU_ALIGN_CHECK_EN  when defined, accesses whose address is not a multiple
//                       of the access size complete immediately with resp_err
//                       and never touch memory. When undefined, the byte
//                       offset is forced down to size alignment and the
//                       access proceeds normally; resp_err is always 0.
//
// Latency from acceptance to resp_valid: misaligned 1, load 2,
// doubleword store 2, sub-word store 3 cycles.
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic                     clk,
    input  logic                     rst,
    load_store_unit_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Offset bits that survive size alignment.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'b111;
            SIZE_HALF: return 3'b110;
            SIZE_WORD: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

`ifdef LSU_ALIGN_CHECK_EN
    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return |off[1:0];
            default:   return |off;
        endcase
    endfunction
`endif

    // Bit mask covering the target bytes within the doubleword.
    function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [63:0] m;
        case (size)
            SIZE_BYTE: m = 64'h0000_0000_0000_00FF;
            SIZE_HALF: m = 64'h0000_0000_0000_FFFF;
            SIZE_WORD: m = 64'h0000_0000_FFFF_FFFF;
            default:   m = '1;
        endcase
        return m << {off, 3'b000};
    endfunction

    // Pick the addressed bytes out of the doubleword and extend to 64 bits.
    function automatic logic [63:0] extract(input logic [63:0] q, input logic [1:0] size,
                                            input logic [2:0] off, input logic uns);
        logic [63:0] s;
        s = q >> {off, 3'b000};
        case (size)
            SIZE_BYTE: return uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            SIZE_HALF: return uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SIZE_WORD: return uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default:   return q;
        endcase
    endfunction

    // Replace the target bytes of the captured doubleword with store data.
    function automatic logic [63:0] merge(input logic [63:0] q, input logic [63:0] wdata,
                                          input logic [1:0] size, input logic [2:0] off);
        logic [63:0] m;
        m = lane_mask(size, off);
        return (q & ~m) | ((wdata << {off, 3'b000}) & m);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,          state_d;
    logic        store_q,          store_d;
    logic [1:0]  size_q,           size_d;
    logic        unsigned_q,       unsigned_d;
    logic [2:0]  off_q,            off_d;
    logic [63:0] wdata_q,          wdata_d;
    logic [63:0] rdata_q,          rdata_d;
    logic        err_q,            err_d;
    logic [63:0] mem_address_q,    mem_address_d;
    logic [63:0] mem_write_data_q, mem_write_data_d;

    logic        misaligned;
    logic [2:0]  req_off;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(bus.req_size, bus.req_addr[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Aligned requests are unaffected; misaligned ones (only reachable when the
    // check is disabled) get their offset rounded down to the access size.
    assign req_off = bus.req_addr[2:0] & align_mask(bus.req_size);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every _d gets its hold value before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        store_d          = store_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        off_d            = off_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d    = bus.req_store;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    off_d      = req_off;
                    wdata_d    = bus.req_wdata;
                    rdata_d    = '0;
                    err_d      = misaligned;
                    if (misaligned) begin
                        // No memory access: memory-side registers keep their values.
                        state_d = S_RESP;
                    end else begin
                        mem_address_d = {3'b000, bus.req_addr[63:3]};
                        if (bus.req_store && (bus.req_size == SIZE_DWORD)) begin
                            mem_write_data_d = bus.req_wdata;
                            state_d          = S_WRITE;
                        end else begin
                            // Loads and sub-word stores both need the current doubleword.
                            state_d = S_READ;
                        end
                    end
                end
            end

            S_READ: begin
                if (store_q) begin
                    mem_write_data_d = merge(bus.mem_q, wdata_q, size_q, off_q);
                    state_d          = S_WRITE;
                end else begin
                    rdata_d = extract(bus.mem_q, size_q, off_q, unsigned_q);
                    state_d = S_RESP;
                end
            end

            S_WRITE: state_d = S_RESP;

            S_RESP:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational block above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            store_q          <= 1'b0;
            size_q           <= SIZE_BYTE;
            unsigned_q       <= 1'b0;
            off_q            <= '0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            err_q            <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            store_q          <= store_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            off_q            <= off_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            err_q            <= err_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Ready is gated by rst directly so it reads 0 throughout reset even
    // though the state register already sits in IDLE.
    assign bus.req_ready      = (state_q == S_IDLE) && !rst;

    // Decoded straight from the state register: the asynchronous reset drops
    // the write enable immediately, aborting a write in progress.
    assign bus.mem_l          = (state_q == S_WRITE);

    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_rdata     = bus.resp_valid ? rdata_q : '0;
    // err_q is only ever set when the alignment check is compiled in.
    assign bus.resp_err       = bus.resp_valid & err_q;

    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A small doubleword memory model serves
// the memory port. Expected responses are queued when a request is driven and
// popped when resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    resp_t sb[$];

    logic [63:0] mem [8] = '{default: '0};

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign bus.mem_q = mem[bus.mem_address[2:0]];

    always @(posedge clk) begin
        if (bus.mem_l) mem[bus.mem_address[2:0]] <= bus.mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the next expected response and compare against the bus.
    task automatic sb_check(input string tag);
        resp_t r;
        if (sb.size() == 0) begin
            check({tag, " sb_nonempty"}, 64'(sb.size()), 64'd1);
        end else begin
            r = sb.pop_front();
            check({tag, " rdata"}, bus.resp_rdata, r.rdata);
            check({tag, " err"}, 64'(bus.resp_err), 64'(r.err));
        end
    endtask

    task automatic drive_idle();
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
    endtask

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic un,
                             input logic [63:0] addr, input logic [63:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    // One complete transaction with latency and memory-write checks.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input int exp_lat, input bit exp_wr, input logic [63:0] exp_wdata,
                          input logic [63:0] exp_rdata, input logic exp_err, input string tag);
        int lat    = 0;
        int writes = 0;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        check({tag, " ready_before"}, 64'(bus.req_ready), 64'd1);
        drive_req(st, sz, un, addr, wd);
        @(posedge clk);
        #1 drive_idle();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_l) begin
                writes++;
                check({tag, " mem_address"}, bus.mem_address, addr >> 3);
                check({tag, " mem_write_data"}, bus.mem_write_data, exp_wdata);
            end
            if (bus.resp_valid) begin
                lat = k;
                sb_check(tag);
                break;
            end
            check({tag, " idle_rdata_zero"}, bus.resp_rdata, 64'd0);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " write_cycles"}, 64'(writes), exp_wr ? 64'd1 : 64'd0);
        @(negedge clk);
        check({tag, " resp_one_cycle"}, 64'(bus.resp_valid), 64'd0);
        check({tag, " ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        drive_idle();

        // ---------------- reset state ----------------
        #3;
        check("rst ready",          64'(bus.req_ready),  64'd0);
        check("rst resp_valid",     64'(bus.resp_valid), 64'd0);
        check("rst resp_rdata",     bus.resp_rdata,      64'd0);
        check("rst resp_err",       64'(bus.resp_err),   64'd0);
        check("rst mem_l",          64'(bus.mem_l),      64'd0);
        check("rst mem_address",    bus.mem_address,     64'd0);
        check("rst mem_write_data", bus.mem_write_data,  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst ready", 64'(bus.req_ready), 64'd1);

        // ---------------- directed accesses ----------------
        do_req(1'b1, 2'b11, 1'b0, 64'h18, 64'hFFEEDDCCBBAA9988,
               2, 1'b1, 64'hFFEEDDCCBBAA9988, 64'd0, 1'b0, "dword_store");
        do_req(1'b0, 2'b01, 1'b0, 64'h18, 64'd0,
               2, 1'b0, 64'd0, 64'hFFFFFFFFFFFF9988, 1'b0, "half_load_s");
        do_req(1'b0, 2'b01, 1'b1, 64'h18, 64'd0,
               2, 1'b0, 64'd0, 64'h0000000000009988, 1'b0, "half_load_u");
`ifdef LSU_ALIGN_CHECK_EN
        do_req(1'b0, 2'b10, 1'b0, 64'h1A, 64'd0,
               1, 1'b0, 64'd0, 64'd0, 1'b1, "word_load_misaligned");
`else
        do_req(1'b0, 2'b10, 1'b0, 64'h1A, 64'd0,
               2, 1'b0, 64'd0, 64'hFFFFFFFFBBAA9988, 1'b0, "word_load_misaligned");
`endif
        do_req(1'b1, 2'b00, 1'b0, 64'h1B, 64'h5A,
               3, 1'b1, 64'hFFEEDDCC5AAA9988, 64'd0, 1'b0, "byte_store");
        do_req(1'b0, 2'b00, 1'b1, 64'h1B, 64'd0,
               2, 1'b0, 64'd0, 64'h000000000000005A, 1'b0, "byte_load_u");
        do_req(1'b0, 2'b00, 1'b0, 64'h1F, 64'd0,
               2, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "byte_load_s");
        do_req(1'b0, 2'b10, 1'b1, 64'h1C, 64'd0,
               2, 1'b0, 64'd0, 64'h00000000FFEEDDCC, 1'b0, "word_load_u");
        do_req(1'b1, 2'b01, 1'b0, 64'h1E, 64'hABCD1234,
               3, 1'b1, 64'h1234DDCC5AAA9988, 64'd0, 1'b0, "half_store");
        do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'd0,
               2, 1'b0, 64'd0, 64'h1234DDCC5AAA9988, 1'b0, "dword_load");

        // ---------------- req_valid held across a busy load ----------------
        sb.push_back('{rdata: 64'h0000000000000088, err: 1'b0});
        sb.push_back('{rdata: 64'h1234DDCC5AAA9988, err: 1'b0});
        @(negedge clk);
        drive_req(1'b0, 2'b00, 1'b1, 64'h18, 64'd0);
        @(posedge clk);
        // Second request appears while busy; it must not disturb the first.
        #1 drive_req(1'b0, 2'b11, 1'b0, 64'h18, 64'd0);
        @(negedge clk);
        check("busy c1 ready", 64'(bus.req_ready),  64'd0);
        check("busy c1 resp",  64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        check("busy c2 ready", 64'(bus.req_ready),  64'd0);
        check("busy c2 resp",  64'(bus.resp_valid), 64'd1);
        sb_check("busy first");
        @(negedge clk);
        check("busy c3 ready", 64'(bus.req_ready),  64'd1);
        check("busy c3 resp",  64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("busy c4 ready", 64'(bus.req_ready),  64'd0);
        @(negedge clk);
        check("busy c5 resp",  64'(bus.resp_valid), 64'd1);
        sb_check("busy second");

        // ---------------- reset asserted mid-WRITE ----------------
        @(negedge clk);
        drive_req(1'b1, 2'b11, 1'b0, 64'h18, 64'hDEADBEEFCAFEF00D);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("abort mem_l before rst", 64'(bus.mem_l), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort mem_l async",  64'(bus.mem_l),      64'd0);
        check("abort resp_valid",   64'(bus.resp_valid), 64'd0);
        check("abort ready in rst", 64'(bus.req_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort ready after", 64'(bus.req_ready),  64'd1);
        check("abort no resp",     64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        check("abort no resp 2",   64'(bus.resp_valid), 64'd0);
        // The aborted write must not have reached memory.
        do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'd0,
               2, 1'b0, 64'd0, 64'h1234DDCC5AAA9988, 1'b0, "after_abort_load");

        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  access request present.
REQ-004 SHALL have port: req_ready  output  1  unit idle, request accepted when req_valid & req_ready at clk edge.
REQ-005 SHALL have port: req_store  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-007 SHALL have port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have port: req_addr  input  64  byte address, little-endian.
REQ-009 SHALL have port: req_wdata  input  64  store data, valid bits in LSBs per req_size.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  64  extended load data; 0 for stores.
REQ-012 SHALL have port: resp_err  output  1  misaligned access, qualified by resp_valid.
REQ-013 SHALL have ports to the downstream data memory: mem_l  output  1  write enable; mem_address  output  64  doubleword index = req_addr >> 3; mem_write_data  output  64; mem_q  input  64  combinational read of mem_address.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL latch all req_* fields on acceptance; inputs ignored while not IDLE.
REQ-016 SHALL transition from IDLE on acceptance as follows: misaligned -> RESP; load -> READ; doubleword store -> WRITE; sub-word store -> READ.
REQ-017 SHALL, in READ, drive mem_l = 0 and capture mem_q at end of cycle; go to RESP for loads, WRITE for stores.
REQ-018 SHALL, in WRITE, assert mem_l for exactly one cycle with merged data (captured doubleword, target bytes at offset req_addr[2:0] replaced by req_wdata LSBs; full req_wdata for doubleword); go to RESP.
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; no backpressure on the response.
REQ-020 SHALL produce resp_valid: load on 2nd cycle after acceptance; doubleword store 2nd; sub-word store 3rd; misaligned 1st.
REQ-021 SHALL extract load data from bytes at offset req_addr[2:0] of mem_q and extend to 64 bits per req_unsigned; doubleword loads unaltered.
REQ-022 SHALL keep mem_l = 0 in every state except WRITE; mem_address and mem_write_data are registered and hold between accesses.
REQ-023 SHALL define misaligned as req_addr not a multiple of access size (byte never misaligned).
REQ-024 SHALL hold resp_rdata and resp_err at 0 when resp_valid = 0.

Reset
REQ-025 SHALL, while rst = 1, force state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_l = 0, mem_address = 0, mem_write_data = 0.
REQ-026 SHALL drop mem_l immediately on rst assertion mid-WRITE, aborting the access; req_ready = 1 from first cycle after rst release.

Configuration
REQ-027 SHALL, with LSU_ALIGN_CHECK_EN defined, detect misalignment per REQ-023: resp_err = 1, no memory access, mem_l never asserted.
REQ-028 SHALL, without LSU_ALIGN_CHECK_EN, never flag misalignment: offset forced down to size alignment, access proceeds normally, resp_err tied 0.

Verification
REQ-029 SHALL cover: doubleword store 0xFFEEDDCCBBAA9988 to 0x18 -> mem_l high one cycle with mem_address = 3, mem_write_data = 0xFFEEDDCCBBAA9988; resp_valid 2nd cycle after accept, resp_err = 0.
REQ-030 SHALL cover: signed half load from 0x18 -> resp_rdata = 0xFFFFFFFFFFFF9988; unsigned -> 0x0000000000009988; mem_l stays 0.
REQ-031 SHALL cover: byte store 0x5A to 0x1B -> READ then WRITE of 0xFFEEDDCC5AAA9988 to index 3; resp_valid 3rd cycle after accept.
REQ-032 SHALL cover: word load at 0x1A with LSU_ALIGN_CHECK_EN -> resp_valid 1st cycle after accept, resp_err = 1, mem_l never high; without macro -> resp_rdata = 0xFFFFFFFFBBAA9988, resp_err = 0.
REQ-033 SHALL cover: rst asserted during WRITE -> mem_l falls without clock edge, resp_valid stays 0, req_ready = 1 first cycle after release.
REQ-034 SHALL cover: req_valid held high across a busy load -> req_ready = 0 until return to IDLE; second request accepted on cycle after RESP.
